// File: rtl/jacobi_1d_pkg.sv
// Shared types and default widths for the jacobi_1d sweep sequencer.
package jacobi_1d_pkg;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_STEPS_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } sweep_state_t;

    // Ping-pong pointer pair; src feeds A_1/A_2, dst feeds B.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] src;
        logic [DEF_ADDR_W-1:0] dst;
    } ptr_pair_t;

endpackage

// File: rtl/jacobi_1d_sweep_ctrl.sv
// Ping-pong sweep sequencer issuing one jacobi_1d call per time step.
// Optional cycle counter on perf_cycles when JACOBI_SWEEP_PERF_EN is defined.
module jacobi_1d_sweep_ctrl
    import jacobi_1d_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int STEPS_W = DEF_STEPS_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic [STEPS_W-1:0] cfg_steps,
    input  logic [ADDR_W-1:0]  cfg_buf_a,
    input  logic [ADDR_W-1:0]  cfg_buf_b,
    output logic               cfg_busy,
    output logic               cfg_done,
    output logic [ADDR_W-1:0]  result_ptr,
    output logic [STEPS_W-1:0] steps_done,
    output logic               stray_done,
    output logic               call_start,
    input  logic               call_busy,
    input  logic               call_done,
    output logic               call_stall,
    output logic [ADDR_W-1:0]  arg_A_1,
    output logic [ADDR_W-1:0]  arg_A_2,
    output logic [ADDR_W-1:0]  arg_B,
    output logic [31:0]        perf_cycles
);

    sweep_state_t       state_reg, state_next;
    ptr_pair_t          ptr_reg, ptr_next;
    logic [STEPS_W-1:0] remaining_reg, remaining_next;
    logic [STEPS_W-1:0] steps_done_reg, steps_done_next;
    logic [ADDR_W-1:0]  result_reg, result_next;
    logic               stray_reg, stray_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            remaining_reg  <= '0;
            steps_done_reg <= '0;
            result_reg     <= '0;
            stray_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            remaining_reg  <= remaining_next;
            steps_done_reg <= steps_done_next;
            result_reg     <= result_next;
            stray_reg      <= stray_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        remaining_next  = remaining_reg;
        steps_done_next = steps_done_reg;
        result_next     = result_reg;
        stray_next      = stray_reg;

        case (state_reg)
            IDLE: begin
                if (cfg_start) begin
                    ptr_next.src    = cfg_buf_a;
                    ptr_next.dst    = cfg_buf_b;
                    remaining_next  = cfg_steps;
                    steps_done_next = '0;
                    stray_next      = 1'b0;
                    if (cfg_steps == '0) begin
                        result_next = cfg_buf_a;
                        state_next  = FINISH;
                    end else begin
                        state_next  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!call_busy) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (call_done) begin
                    steps_done_next = steps_done_reg + STEPS_W'(1);
                    remaining_next  = remaining_reg - STEPS_W'(1);
                    ptr_next.src    = ptr_reg.dst;
                    ptr_next.dst    = ptr_reg.src;
                    if (remaining_reg == STEPS_W'(1)) begin
                        result_next = ptr_reg.dst;
                        state_next  = FINISH;
                    end else begin
                        state_next  = ISSUE;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A return with nothing outstanding is absorbed but remembered.
        if (call_done && state_reg != WAIT) begin
            stray_next = 1'b1;
        end
    end

    assign call_start = (state_reg == ISSUE);
    assign cfg_busy   = (state_reg == ISSUE) || (state_reg == WAIT);
    assign cfg_done   = (state_reg == FINISH);
    assign call_stall = 1'b0;
    assign arg_A_1    = ptr_reg.src;
    assign arg_A_2    = ptr_reg.src;
    assign arg_B      = ptr_reg.dst;
    assign result_ptr = result_reg;
    assign steps_done = steps_done_reg;
    assign stray_done = stray_reg;

`ifdef JACOBI_SWEEP_PERF_EN
    logic [31:0] perf_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_reg <= '0;
        end else if (state_reg == IDLE && cfg_start) begin
            perf_reg <= '0;
        end else if (cfg_busy && perf_reg != 32'hFFFF_FFFF) begin
            perf_reg <= perf_reg + 32'd1;
        end
    end

    assign perf_cycles = perf_reg;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_jacobi_1d_sweep_ctrl.sv
// Self-checking bench for jacobi_1d_sweep_ctrl: directed scenarios plus random sweeps.
module tb_jacobi_1d_sweep_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [15:0] cfg_steps;
    logic [63:0] cfg_buf_a, cfg_buf_b;
    logic        cfg_busy, cfg_done;
    logic [63:0] result_ptr;
    logic [15:0] steps_done;
    logic        stray_done;
    logic        call_start, call_busy, call_done, call_stall;
    logic [63:0] arg_A_1, arg_A_2, arg_B;
    logic [31:0] perf_cycles;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    jacobi_1d_sweep_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_start   (cfg_start),
        .cfg_steps   (cfg_steps),
        .cfg_buf_a   (cfg_buf_a),
        .cfg_buf_b   (cfg_buf_b),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .result_ptr  (result_ptr),
        .steps_done  (steps_done),
        .stray_done  (stray_done),
        .call_start  (call_start),
        .call_busy   (call_busy),
        .call_done   (call_done),
        .call_stall  (call_stall),
        .arg_A_1     (arg_A_1),
        .arg_A_2     (arg_A_2),
        .arg_B       (arg_B),
        .perf_cycles (perf_cycles)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: call i reads buffer a on even steps, b on odd; final data sits
    // in b after an odd number of steps, in a otherwise.
    function automatic logic [63:0] ref_src(input int i, input logic [63:0] a, input logic [63:0] b);
        return (i % 2 == 0) ? a : b;
    endfunction

    function automatic logic [63:0] ref_result(input int steps, input logic [63:0] a, input logic [63:0] b);
        return (steps % 2 == 1) ? b : a;
    endfunction

    // Entered and left just after a rising edge. With reset_mid set, returns right
    // after the first call is accepted, with reset driven high.
    task automatic run_sweep(input int steps, input logic [63:0] a, input logic [63:0] b,
                             input int lat, input int stall_call, input int stall_len,
                             input bit restart, input bit reset_mid);
        int ncalls = 0;
        int countdown = 0;
        int stall_left = stall_len;
        int stalled = 0;
        int guard = 0;
        int start_cyc;
        bit prev_stalled = 1'b0;
        bit done = 1'b0;
        bit restart_sent = 1'b0;
        logic [63:0] exp_perf;

        cfg_start = 1'b1;
        cfg_steps = 16'(steps);
        cfg_buf_a = a;
        cfg_buf_b = b;
        call_busy = (stall_call == 0 && stall_len > 0);
        @(posedge clock); #1;
        start_cyc = cyc;
        cfg_start = 1'b0;
        cfg_steps = 16'($urandom);
        cfg_buf_a = {$urandom, $urandom};
        cfg_buf_b = {$urandom, $urandom};

        while (!done && guard < 3000) begin
            @(negedge clock);
            guard++;
            if (cfg_done) begin
                done = 1'b1;
`ifdef JACOBI_SWEEP_PERF_EN
                exp_perf = 64'(cyc - start_cyc);
`else
                exp_perf = 64'd0;
`endif
                check_eq("result_ptr", result_ptr, ref_result(steps, a, b));
                check_eq("steps_done", 64'(steps_done), 64'(steps));
                check_eq("accepted_calls", 64'(ncalls), 64'(steps));
                check_eq("busy_at_done", 64'(cfg_busy), 64'd0);
                check_eq("stray_in_sweep", 64'(stray_done), 64'd0);
                check_eq("call_stall", 64'(call_stall), 64'd0);
                check_eq("perf_cycles", 64'(perf_cycles), exp_perf);
                if (stall_call < steps)
                    check_eq("stall_cycles", 64'(stalled), 64'(stall_len));
                $display("[TB] sweep steps=%0d a=%h b=%h lat=%0d result=%h cycles=%0d",
                         steps, a, b, lat, result_ptr, cyc - start_cyc);
            end else begin
                check_eq("busy_in_sweep", 64'(cfg_busy), 64'd1);
                if (call_start) begin
                    check_eq("arg_A_1", arg_A_1, ref_src(ncalls, a, b));
                    check_eq("arg_A_2", arg_A_2, ref_src(ncalls, a, b));
                    check_eq("arg_B", arg_B, ref_src(ncalls + 1, a, b));
                    if (call_busy) begin
                        stalled++;
                        stall_left--;
                    end else begin
                        ncalls++;
                        countdown = lat;
                    end
                end else if (prev_stalled) begin
                    check_eq("start_held", 64'(call_start), 64'd1);
                end
                prev_stalled = call_start && call_busy;
            end

            @(posedge clock); #1;
            if (reset_mid && ncalls == 1) begin
                call_busy = 1'b0;
                call_done = 1'b0;
                reset = 1'b1;
                return;
            end
            call_done = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) call_done = 1'b1;
            end
            call_busy = (ncalls == stall_call && stall_left > 0);
            if (restart && !restart_sent && countdown > 0 && !call_done) begin
                cfg_start = 1'b1;
                cfg_steps = 16'd7;
                restart_sent = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
        end

        if (!done) begin
            check_eq("sweep_timeout", 64'd0, 64'd1);
            return;
        end
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("done_pulse_width", 64'(cfg_done), 64'd0);
        check_eq("perf_hold", 64'(perf_cycles), exp_perf);
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1;
        cfg_start = 1'b0;
        cfg_steps = '0;
        cfg_buf_a = '0;
        cfg_buf_b = '0;
        call_busy = 1'b0;
        call_done = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("rst_busy", 64'(cfg_busy), 64'd0);
        check_eq("rst_done", 64'(cfg_done), 64'd0);
        check_eq("rst_start", 64'(call_start), 64'd0);
        check_eq("rst_stall", 64'(call_stall), 64'd0);
        check_eq("rst_stray", 64'(stray_done), 64'd0);
        check_eq("rst_steps", 64'(steps_done), 64'd0);
        check_eq("rst_result", result_ptr, 64'd0);
        check_eq("rst_args", arg_A_1 | arg_A_2 | arg_B, 64'd0);
        check_eq("rst_perf", 64'(perf_cycles), 64'd0);
        @(posedge clock); #1;

        // Basic ping-pong, zero steps, backpressure, ignored restart.
        run_sweep(3, 64'h1000, 64'h2000, 5, 99, 0, 1'b0, 1'b0);
        run_sweep(0, 64'h3000, 64'h4000, 5, 99, 0, 1'b0, 1'b0);
        run_sweep(2, 64'h5000, 64'h6000, 3, 1, 4, 1'b0, 1'b0);
        run_sweep(2, 64'h7000, 64'h8000, 4, 99, 0, 1'b1, 1'b0);

        // Reset while a call is outstanding; its return shows up as a stray.
        run_sweep(3, 64'h9000, 64'hA000, 5, 99, 0, 1'b0, 1'b1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        call_done = 1'b1;
        @(negedge clock);
        check_eq("post_rst_idle", 64'(cfg_busy), 64'd0);
        check_eq("post_rst_nostart", 64'(call_start), 64'd0);
        @(posedge clock); #1;
        call_done = 1'b0;
        @(negedge clock);
        check_eq("stray_set", 64'(stray_done), 64'd1);
        check_eq("stray_no_advance", 64'(cfg_busy | cfg_done), 64'd0);
        check_eq("stray_steps", 64'(steps_done), 64'd0);
        @(posedge clock); #1;
        run_sweep(1, 64'hB000, 64'hC000, 10, 99, 0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_sweep($urandom_range(0, 6), {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
